// File: rtl/md_pkg.sv
// md_pkg: shared types and constants for the Magical Dartboard statistics slice.
//   md_state_e : report FSM states, 2-bit encoding
//   MD_SUM_W   : width of one round score, shared with the dartboard round engine
package md_pkg;

  localparam int MD_SUM_W = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIST  = 2'd1,
    BEST  = 2'd2,
    TOTAL = 2'd3
  } md_state_e;

endpackage

// File: rtl/md_hist_buf.sv
// md_hist_buf: circular history of the last DEPTH round scores.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : synchronous wipe of pointer and count
//   wr_en        : store wr_data at the write pointer this cycle
//   wr_data      : round score to store
//   rd_idx       : combinational read index
//   rd_data      : entry at rd_idx (forwards wr_data when reading the slot being written)
//   wr_ptr_nxt   : write pointer after this cycle's update
//   count_nxt    : saturating entry count after this cycle's update
module md_hist_buf
  import md_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [MD_SUM_W-1:0]      wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_idx,
  output logic [MD_SUM_W-1:0]      rd_data,
  output logic [$clog2(DEPTH)-1:0] wr_ptr_nxt,
  output logic [$clog2(DEPTH):0]   count_nxt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [MD_SUM_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]    wr_ptr;
  logic [PTR_W:0]      count;

  // Pointer wraps naturally because DEPTH is a power of two; count sticks at DEPTH
  // so that once full every new round overwrites the oldest slot.
  always_comb begin
    wr_ptr_nxt = wr_ptr;
    count_nxt  = count;
    if (clear) begin
      wr_ptr_nxt = '0;
      count_nxt  = '0;
    end else if (wr_en) begin
      wr_ptr_nxt = wr_ptr + 1'b1;
      if (count != (PTR_W+1)'(DEPTH))
        count_nxt = count + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr_nxt;
      count  <= count_nxt;
    end
  end

  // Storage needs no reset: count gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= wr_data;
  end

  // Write-through lets a report launched in the same cycle as a capture see that round.
  assign rd_data = (wr_en && (rd_idx == wr_ptr)) ? wr_data : mem[rd_idx];

endmodule

// File: rtl/md_scoreboard.sv
// md_scoreboard: round statistics and report streamer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   in_valid   : round result strobe, in_sum sampled when high
//   in_sum     : round score
//   query      : report request, honoured only when idle
//   clear      : synchronous wipe of statistics and FSM, highest priority
//   out_valid  : report beat valid
//   out_data   : beat payload (history oldest-first, best, total), 0 when not valid
//   out_last   : marks the total beat
//   busy       : report in progress
//   dropped    : sticky, a round arrived while busy and was discarded
module md_scoreboard
  import md_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int TOT_W = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  input  logic [MD_SUM_W-1:0] in_sum,
  input  logic                query,
  input  logic                clear,
  output logic                out_valid,
  output logic [TOT_W-1:0]    out_data,
  output logic                out_last,
  output logic                busy,
  output logic                dropped
);

  localparam int               PTR_W   = $clog2(DEPTH);
  localparam logic [TOT_W-1:0] TOT_MAX = '1;

  md_state_e           state, state_nxt;
  logic [PTR_W-1:0]    rd_ptr, rd_ptr_nxt, wr_ptr_nxt;
  logic [PTR_W:0]      remain, remain_nxt, count_nxt;
  logic [MD_SUM_W-1:0] best, best_nxt, rd_data;
  logic [TOT_W-1:0]    total, total_nxt;
  logic [TOT_W:0]      total_sum;
  logic                capture;
  logic                out_valid_nxt, out_last_nxt, dropped_nxt;
  logic [TOT_W-1:0]    out_data_nxt;

  // Rounds are only accepted while no report is running, so a report never sees
  // statistics change underneath it.
  assign capture = in_valid && (state == IDLE) && !clear;

  md_hist_buf #(.DEPTH(DEPTH)) u_hist (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear),
    .wr_en      (capture),
    .wr_data    (in_sum),
    .rd_idx     (rd_ptr_nxt),
    .rd_data    (rd_data),
    .wr_ptr_nxt (wr_ptr_nxt),
    .count_nxt  (count_nxt)
  );

  // Best score and saturating running total.
  always_comb begin
    best_nxt  = best;
    total_nxt = total;
    total_sum = {1'b0, total} + (TOT_W+1)'(in_sum);
    if (clear) begin
      best_nxt  = '0;
      total_nxt = '0;
    end else if (capture) begin
      if (in_sum > best)
        best_nxt = in_sum;
      total_nxt = total_sum[TOT_W] ? TOT_MAX : total_sum[TOT_W-1:0];
    end
  end

  // State register: the state names the beat being presented on the outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      rd_ptr <= '0;
      remain <= '0;
      best   <= '0;
      total  <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_ptr_nxt;
      remain <= remain_nxt;
      best   <= best_nxt;
      total  <= total_nxt;
    end
  end

  // Next-state logic. The query uses post-capture pointer and count so a round
  // arriving with the query is part of the report; remain counts history beats
  // still to come after the current one.
  always_comb begin
    state_nxt  = state;
    rd_ptr_nxt = rd_ptr;
    remain_nxt = remain;
    if (clear) begin
      state_nxt  = IDLE;
      rd_ptr_nxt = '0;
      remain_nxt = '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (query) begin
            if (count_nxt != '0) begin
              state_nxt  = HIST;
              rd_ptr_nxt = wr_ptr_nxt - count_nxt[PTR_W-1:0];
              remain_nxt = count_nxt - 1'b1;
            end else begin
              state_nxt = BEST;
            end
          end
        end
        HIST: begin
          if (remain == '0) begin
            state_nxt = BEST;
          end else begin
            rd_ptr_nxt = rd_ptr + 1'b1;
            remain_nxt = remain - 1'b1;
          end
        end
        BEST:    state_nxt = TOTAL;
        TOTAL:   state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Output decode from the next state, so each beat is registered in the same
  // edge that enters its state and all outputs leave flops directly.
  always_comb begin
    out_valid_nxt = (state_nxt != IDLE);
    out_last_nxt  = (state_nxt == TOTAL);
    out_data_nxt  = '0;
    unique case (state_nxt)
      HIST:    out_data_nxt = TOT_W'(rd_data);
      BEST:    out_data_nxt = TOT_W'(best_nxt);
      TOTAL:   out_data_nxt = total_nxt;
      default: out_data_nxt = '0;
    endcase
    dropped_nxt = clear ? 1'b0 : (dropped || (in_valid && (state != IDLE)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      out_valid <= out_valid_nxt;
      out_data  <= out_data_nxt;
      out_last  <= out_last_nxt;
      busy      <= out_valid_nxt;
      dropped   <= dropped_nxt;
    end
  end

endmodule

// File: tb/tb_md_scoreboard.sv
// tb_md_scoreboard: self-checking bench for md_scoreboard (DEPTH=8, TOT_W=10).
// A queue-based model predicts every output cycle; table vectors and short
// hand-written sequences add fixed expected reports for the documented cases.
module tb_md_scoreboard;

  localparam int DEPTH   = 8;
  localparam int TOT_W   = 10;
  localparam int TOT_MAX = 1023;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic [6:0]       in_sum;
  logic             query;
  logic             clear;
  logic             out_valid;
  logic [TOT_W-1:0] out_data;
  logic             out_last;
  logic             busy;
  logic             dropped;

  md_scoreboard #(.DEPTH(DEPTH), .TOT_W(TOT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_sum    (in_sum),
    .query     (query),
    .clear     (clear),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy),
    .dropped   (dropped)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model: statistics plus a queue of report beats still to be shown.
  int m_hist[$];
  int m_best;
  int m_total;
  int m_dropped;
  int m_rep[$];

  int tests  = 0;
  int errors = 0;

  int got_n;
  int got_data[32];
  int got_last[32];
  int exp_n;
  int exp_data[32];

  typedef struct packed {
    logic [4:0]       n_rounds;
    logic [10:0][6:0] rounds;
    logic [4:0]       n_beats;
    logic [9:0][9:0]  beats;
  } vec_t;

  vec_t vecs[4];

  task automatic checkVal(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic modelReset();
    m_hist.delete();
    m_rep.delete();
    m_best    = 0;
    m_total   = 0;
    m_dropped = 0;
  endtask

  // One clock edge of the model, applying the rules at the level of rounds and reports.
  task automatic modelStep(input logic v, input int s, input logic q, input logic c);
    if (c) begin
      modelReset();
    end else if (m_rep.size() != 0) begin
      if (v) m_dropped = 1;
      void'(m_rep.pop_front());
    end else begin
      if (v) begin
        m_hist.push_back(s);
        if (m_hist.size() > DEPTH) void'(m_hist.pop_front());
        if (s > m_best) m_best = s;
        m_total = (m_total + s > TOT_MAX) ? TOT_MAX : m_total + s;
      end
      if (q) begin
        foreach (m_hist[i]) m_rep.push_back(m_hist[i]);
        m_rep.push_back(m_best);
        m_rep.push_back(m_total);
      end
    end
  endtask

  task automatic checkOutput();
    int ev;
    ev = (m_rep.size() != 0) ? 1 : 0;
    checkVal("out_valid", int'(out_valid), ev);
    checkVal("busy", int'(busy), ev);
    checkVal("out_data", int'(out_data), ev ? m_rep[0] : 0);
    checkVal("out_last", int'(out_last), (m_rep.size() == 1) ? 1 : 0);
    checkVal("dropped", int'(dropped), m_dropped);
  endtask

  // Drive one cycle of inputs, advance past the edge, then compare against the model.
  task automatic applyStimulus(input logic v, input logic [6:0] s, input logic q, input logic c);
    in_valid = v;
    in_sum   = s;
    query    = q;
    clear    = c;
    @(posedge clk);
    #1;
    modelStep(v, int'(s), q, c);
    checkOutput();
    in_valid = 1'b0;
    query    = 1'b0;
    clear    = 1'b0;
  endtask

  // Records beats of the running report, optionally injecting inputs at one beat.
  task automatic collectReport(input int inj_at, input logic inj_v, input logic [6:0] inj_s,
                               input logic inj_q, input logic inj_c);
    got_n = 0;
    while (out_valid && got_n < 20) begin
      got_data[got_n] = int'(out_data);
      got_last[got_n] = int'(out_last);
      if (got_n == inj_at) applyStimulus(inj_v, inj_s, inj_q, inj_c);
      else                 applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
      got_n++;
    end
    if (out_valid) begin
      tests++;
      errors++;
      $display("[TB] FAIL report_timeout: got more than %0d beats, expected at most 10", got_n);
    end
  endtask

  task automatic checkReport(input string name);
    checkVal({name, "_len"}, got_n, exp_n);
    for (int i = 0; i < exp_n && i < got_n; i++) begin
      checkVal($sformatf("%s_beat%0d", name, i), got_data[i], exp_data[i]);
      checkVal($sformatf("%s_last%0d", name, i), got_last[i], (i == exp_n - 1) ? 1 : 0);
    end
  endtask

  task automatic setExp3(input int a, input int b, input int c);
    exp_n       = 3;
    exp_data[0] = a;
    exp_data[1] = b;
    exp_data[2] = c;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    vecs[0] = '0;
    vecs[0].n_beats = 5'd2;

    vecs[1] = '0;
    vecs[1].n_rounds  = 5'd3;
    vecs[1].rounds[0] = 7'd12;
    vecs[1].rounds[1] = 7'd40;
    vecs[1].rounds[2] = 7'd7;
    vecs[1].n_beats   = 5'd5;
    vecs[1].beats[0]  = 10'd12;
    vecs[1].beats[1]  = 10'd40;
    vecs[1].beats[2]  = 10'd7;
    vecs[1].beats[3]  = 10'd40;
    vecs[1].beats[4]  = 10'd59;

    vecs[2] = '0;
    vecs[2].n_rounds = 5'd11;
    for (int i = 0; i < 11; i++) vecs[2].rounds[i] = 7'd127;
    vecs[2].n_beats = 5'd10;
    for (int i = 0; i < 9; i++) vecs[2].beats[i] = 10'd127;
    vecs[2].beats[9] = 10'd1023;

    vecs[3] = '0;
    vecs[3].n_rounds = 5'd10;
    for (int i = 0; i < 10; i++) vecs[3].rounds[i] = 7'(i + 1);
    vecs[3].n_beats = 5'd10;
    for (int i = 0; i < 8; i++) vecs[3].beats[i] = 10'(i + 3);
    vecs[3].beats[8] = 10'd10;
    vecs[3].beats[9] = 10'd55;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_sum   = '0;
    query    = 1'b0;
    clear    = 1'b0;
    modelReset();
    #12;
    checkVal("rst_out_valid", int'(out_valid), 0);
    checkVal("rst_out_data", int'(out_data), 0);
    checkVal("rst_busy", int'(busy), 0);
    checkVal("rst_dropped", int'(dropped), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table vectors: clear, play rounds, query, compare whole report.
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
      for (int r = 0; r < int'(vecs[k].n_rounds); r++)
        applyStimulus(1'b1, vecs[k].rounds[r], 1'b0, 1'b0);
      applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
      collectReport(-1, 1'b0, 7'd0, 1'b0, 1'b0);
      exp_n = int'(vecs[k].n_beats);
      for (int i = 0; i < exp_n; i++) exp_data[i] = int'(vecs[k].beats[i]);
      checkReport($sformatf("vec%0d", k));
    end

    // Round and query in the same idle cycle: the round is part of the report.
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b1);
    applyStimulus(1'b1, 7'd20, 1'b1, 1'b0);
    collectReport(-1, 1'b0, 7'd0, 1'b0, 1'b0);
    setExp3(20, 20, 20);
    checkReport("simul");

    // Round during a report is discarded and flagged.
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(0, 1'b1, 7'd50, 1'b0, 1'b0);
    checkVal("dropped_set", int'(dropped), 1);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(-1, 1'b0, 7'd0, 1'b0, 1'b0);
    setExp3(20, 20, 20);
    checkReport("drop_absent");

    // Queries mid-report and on the last beat are ignored.
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(1, 1'b0, 7'd0, 1'b1, 1'b0);
    checkReport("requery_mid");
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(2, 1'b0, 7'd0, 1'b1, 1'b0);
    checkReport("requery_last");
    applyStimulus(1'b0, 7'd0, 1'b0, 1'b0);
    checkVal("requery_idle", int'(out_valid), 0);

    // Clear during a history beat aborts the report and wipes everything.
    applyStimulus(1'b1, 7'd12, 1'b0, 1'b0);
    applyStimulus(1'b1, 7'd40, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(1, 1'b0, 7'd0, 1'b0, 1'b1);
    checkVal("clear_abort_len", got_n, 2);
    checkVal("clear_abort_valid", int'(out_valid), 0);
    checkVal("clear_dropped", int'(dropped), 0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(-1, 1'b0, 7'd0, 1'b0, 1'b0);
    exp_n       = 2;
    exp_data[0] = 0;
    exp_data[1] = 0;
    checkReport("after_clear");

    // Asynchronous reset mid-report drops outputs without waiting for an edge.
    applyStimulus(1'b1, 7'd33, 1'b0, 1'b0);
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    checkVal("arst_out_valid", int'(out_valid), 0);
    checkVal("arst_out_data", int'(out_data), 0);
    checkVal("arst_busy", int'(busy), 0);
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(1'b0, 7'd0, 1'b1, 1'b0);
    collectReport(-1, 1'b0, 7'd0, 1'b0, 1'b0);
    checkReport("after_arst");

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      applyStimulus(($urandom % 3) == 0, 7'($urandom % 128),
                    ($urandom % 8) == 0, ($urandom % 70) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
